// File: rtl/vram_packet_tx.sv
// vram_packet_tx: reads a run of RGB pixels from VRAM and streams them as a headed byte packet to a TX MAC.
module vram_packet_tx #(
  parameter int         PIXELS = 8,
  parameter logic [7:0] HDR0   = 8'h05,
  parameter logic [7:0] HDR1   = 8'hA8
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] start_addr,
  output logic        busy,
  output logic        done,
  output logic        vram_rd,
  output logic [23:0] vram_addr,
  input  logic [23:0] vram_data,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int PW = $clog2(PIXELS + 1);
  typedef enum logic [1:0] {IDLE, HDR, PIX, FIN} state_t;
  state_t        r_state;
  logic [2:0]    r_idx;
  logic [1:0]    r_ph;
  logic [PW-1:0] r_pix;
  logic [23:0]   r_addr, r_vaddr, r_rgb;
  logic [7:0]    r_b;
  logic          r_rd_d;
  logic          w_acc, w_last_pix;
  logic [7:0]    w_hdr;
  assign tx_en      = r_state == HDR || r_state == PIX;
  assign busy       = tx_en;
  assign done       = r_state == FIN;
  assign w_acc      = tx_en && tx_ready;
  assign w_last_pix = r_pix == PW'(PIXELS - 1);
  // Pixel 0 is fetched on header byte 5, later pixels on the previous pixel's G byte.
  assign vram_rd    = w_acc && (r_state == HDR ? r_idx == 3'd5 : r_ph == 2'd1 && !w_last_pix);
  assign vram_addr  = vram_rd ? (r_state == HDR ? r_addr : r_addr + 24'(r_pix) + 24'd1) : r_vaddr;
  always_comb begin
    w_hdr = r_idx == 3'd0 ? HDR0 :
            r_idx == 3'd1 ? HDR1 :
            r_idx == 3'd4 ? r_addr[23:16] :
            r_idx == 3'd5 ? r_addr[15:8] :
            r_idx == 3'd6 ? r_addr[7:0] : 8'h00;
    tx_data = r_state == HDR ? w_hdr :
              r_state == PIX ? (r_ph == 2'd0 ? r_rgb[23:16] : r_ph == 2'd1 ? r_rgb[15:8] : r_b) : 8'h00;
  end
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ph    <= '0;
      r_pix   <= '0;
      r_addr  <= '0;
      r_vaddr <= '0;
      r_rgb   <= '0;
      r_b     <= '0;
      r_rd_d  <= 1'b0;
    end else begin
      r_rd_d <= vram_rd;
      if (r_rd_d) r_rgb <= vram_data;
      if (vram_rd) r_vaddr <= vram_addr;
      case (r_state)
        IDLE: if (start) begin
          r_addr  <= start_addr;
          r_idx   <= '0;
          r_state <= HDR;
        end
        HDR: if (tx_ready) begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd6) begin
            r_state <= PIX;
            r_ph    <= '0;
            r_pix   <= '0;
          end
        end
        PIX: if (tx_ready) begin
          // B is parked before the next pixel's fetch overwrites r_rgb.
          if (r_ph == 2'd1) r_b <= r_rgb[7:0];
          r_ph <= r_ph == 2'd2 ? 2'd0 : r_ph + 2'd1;
          if (r_ph == 2'd2) begin
            r_pix <= r_pix + PW'(1);
            if (w_last_pix) r_state <= FIN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_packet_tx.sv
// tb_vram_packet_tx: directed checks of packet bytes, VRAM reads, stalls, ignored starts, wrap and reset.
module tb_vram_packet_tx;
  logic        dclk = 0, rst = 1, start = 0, tx_ready = 0;
  logic [23:0] start_addr = 0, vram_data, vram_addr;
  logic        busy, done, vram_rd, tx_en;
  logic [7:0]  tx_data;
  int          pass_cnt = 0, total = 0;
  vram_packet_tx dut (
    .dclk(dclk), .rst(rst), .start(start), .start_addr(start_addr), .busy(busy), .done(done),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data), .tx_en(tx_en),
    .tx_data(tx_data), .tx_ready(tx_ready)
  );
  always #5 dclk = ~dclk;
  // VRAM returns the low address byte and its two successors; garbage when no read is pending.
  always @(posedge dclk)
    vram_data <= vram_rd ? {vram_addr[7:0], vram_addr[7:0] + 8'd1, vram_addr[7:0] + 8'd2} : 24'hBAD0BA;
  logic        clr = 0, prev_stall, prev_busy, lat_en;
  logic [7:0]  prev_data, lat_data;
  logic [7:0]  cap[$];
  logic [23:0] rdq[$];
  int          cyc = 0, done_cnt, done_cyc, last_acc, first_en, en_cnt, stall_cyc, hold_bad, busy_rise;
  always @(negedge dclk) begin
    cyc++;
    if (clr) begin
      cap.delete(); rdq.delete();
      done_cnt = 0; done_cyc = 0; last_acc = 0; first_en = -1; en_cnt = 0;
      stall_cyc = 0; hold_bad = 0; busy_rise = 0; prev_stall = 0; prev_busy = busy; prev_data = 0;
    end else begin
      if (tx_en && tx_ready) begin cap.push_back(tx_data); last_acc = cyc; end
      if (tx_en) begin en_cnt++; if (first_en < 0) first_en = cyc; end
      if (vram_rd) rdq.push_back(vram_addr);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_stall && tx_data !== prev_data) hold_bad++;
      if (tx_en && !tx_ready) stall_cyc++;
      if (busy && !prev_busy) busy_rise++;
      prev_stall = tx_en && !tx_ready;
      prev_data  = tx_data;
      prev_busy  = busy;
    end
  end
  function automatic logic [7:0] exp_byte(input logic [23:0] a, input int i);
    logic [23:0] p;
    if (i == 0) return 8'h05;
    if (i == 1) return 8'hA8;
    if (i < 4) return 8'h00;
    if (i == 4) return a[23:16];
    if (i == 5) return a[15:8];
    if (i == 6) return a[7:0];
    p = a + 24'((i - 7) / 3);
    return p[7:0] + 8'((i - 7) % 3);
  endfunction
  task automatic clear_mon();
    clr = 1;
    @(negedge dclk);
    #1 clr = 0;
  endtask
  task automatic send(input logic [23:0] a, input bit stall, input bit poke, output bit ok);
    int n, n_cyc, sidx, scnt;
    clear_mon();
    @(posedge dclk); #1;
    start_addr = a; start = 1; tx_ready = 1;
    @(posedge dclk); #1;
    lat_en = tx_en; lat_data = tx_data;
    start = 0; start_addr = 24'h777777;
    n_cyc = 0; sidx = -1; scnt = 0;
    while (done_cnt == 0 && n_cyc < 400) begin
      n = cap.size();
      if (stall && (n == 4 || n == 14 || n == 18) && n != sidx) begin
        if (scnt < 3) begin tx_ready = 0; scnt++; end
        else begin tx_ready = 1; sidx = n; scnt = 0; end
      end else tx_ready = 1;
      start = poke && (n_cyc == 3 || n_cyc == 15);
      @(posedge dclk); #1;
      n_cyc++;
    end
    start = 0; tx_ready = 1;
    ok = done_cnt != 0;
    repeat (3) @(posedge dclk);
    #1;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge dclk);
    #1;
    total++; if (busy !== 0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total++; if (tx_en !== 0) $display("FAIL reset_tx_en: got %b want 0", tx_en); else pass_cnt++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else pass_cnt++;
    total++; if (vram_rd !== 0) $display("FAIL reset_vram_rd: got %b want 0", vram_rd); else pass_cnt++;
    total++; if (vram_addr !== 24'h0) $display("FAIL reset_vram_addr: got %h want 000000", vram_addr); else pass_cnt++;
    rst = 0;
    @(posedge dclk); #1;
  endtask
  task automatic test_basic();
    bit ok; int nbad;
    send(24'h000000, 0, 0, ok);
    total++; if (!ok) $display("FAIL basic_done_timeout: got no done want done"); else pass_cnt++;
    total++; if (lat_en !== 1 || lat_data !== 8'h05) $display("FAIL basic_latency: got en=%b data=%h want en=1 data=05", lat_en, lat_data); else pass_cnt++;
    nbad = 0; foreach (cap[i]) if (cap[i] !== exp_byte(24'h0, i)) nbad++;
    total++; if (cap.size() != 31 || nbad != 0) $display("FAIL basic_bytes: got %0d bytes %0d wrong want 31 bytes 0 wrong", cap.size(), nbad); else pass_cnt++;
    nbad = 0; foreach (rdq[i]) if (rdq[i] !== 24'(i)) nbad++;
    total++; if (rdq.size() != 8 || nbad != 0) $display("FAIL basic_reads: got %0d reads %0d wrong want 8 reads 0 wrong", rdq.size(), nbad); else pass_cnt++;
    total++; if (done_cyc != last_acc + 1) $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_acc + 1); else pass_cnt++;
    total++; if (en_cnt != 31 || last_acc - first_en != 30) $display("FAIL basic_throughput: got en=%0d span=%0d want en=31 span=30", en_cnt, last_acc - first_en); else pass_cnt++;
    total++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else pass_cnt++;
  endtask
  task automatic test_two_addrs();
    bit ok; int nbad;
    logic [23:0] a;
    for (int t = 0; t < 2; t++) begin
      a = t == 0 ? 24'd50 : 24'd100;
      send(a, 0, 0, ok);
      total++; if (!ok) $display("FAIL addr_done_timeout: got no done want done at %h", a); else pass_cnt++;
      nbad = 0; foreach (cap[i]) if (cap[i] !== exp_byte(a, i)) nbad++;
      total++; if (cap.size() != 31 || nbad != 0) $display("FAIL addr_bytes: got %0d bytes %0d wrong want 31 bytes 0 wrong at %h", cap.size(), nbad, a); else pass_cnt++;
      nbad = 0; foreach (rdq[i]) if (rdq[i] !== a + 24'(i)) nbad++;
      total++; if (rdq.size() != 8 || nbad != 0) $display("FAIL addr_reads: got %0d reads %0d wrong want 8 reads 0 wrong at %h", rdq.size(), nbad, a); else pass_cnt++;
    end
  endtask
  task automatic test_stall();
    bit ok; int nbad;
    send(24'h000000, 1, 0, ok);
    total++; if (!ok) $display("FAIL stall_done_timeout: got no done want done"); else pass_cnt++;
    nbad = 0; foreach (cap[i]) if (cap[i] !== exp_byte(24'h0, i)) nbad++;
    total++; if (cap.size() != 31 || nbad != 0) $display("FAIL stall_bytes: got %0d bytes %0d wrong want 31 bytes 0 wrong", cap.size(), nbad); else pass_cnt++;
    nbad = 0; foreach (rdq[i]) if (rdq[i] !== 24'(i)) nbad++;
    total++; if (rdq.size() != 8 || nbad != 0) $display("FAIL stall_reads: got %0d reads %0d wrong want 8 reads 0 wrong", rdq.size(), nbad); else pass_cnt++;
    total++; if (stall_cyc != 9) $display("FAIL stall_cycles: got %0d want 9", stall_cyc); else pass_cnt++;
    total++; if (hold_bad != 0) $display("FAIL stall_hold: got %0d changes want 0", hold_bad); else pass_cnt++;
  endtask
  task automatic test_ignore_start();
    bit ok; int nbad;
    send(24'h000010, 0, 1, ok);
    repeat (10) @(posedge dclk);
    #1;
    total++; if (!ok) $display("FAIL ignore_done_timeout: got no done want done"); else pass_cnt++;
    nbad = 0; foreach (cap[i]) if (cap[i] !== exp_byte(24'h10, i)) nbad++;
    total++; if (cap.size() != 31 || nbad != 0) $display("FAIL ignore_bytes: got %0d bytes %0d wrong want 31 bytes 0 wrong", cap.size(), nbad); else pass_cnt++;
    total++; if (busy_rise != 1 || done_cnt != 1 || en_cnt != 31) $display("FAIL ignore_single: got rises=%0d dones=%0d en=%0d want 1 1 31", busy_rise, done_cnt, en_cnt); else pass_cnt++;
  endtask
  task automatic test_wrap();
    bit ok; int nbad;
    send(24'hFFFFFE, 0, 0, ok);
    total++; if (!ok) $display("FAIL wrap_done_timeout: got no done want done"); else pass_cnt++;
    nbad = 0; foreach (cap[i]) if (cap[i] !== exp_byte(24'hFFFFFE, i)) nbad++;
    total++; if (cap.size() != 31 || nbad != 0) $display("FAIL wrap_bytes: got %0d bytes %0d wrong want 31 bytes 0 wrong", cap.size(), nbad); else pass_cnt++;
    nbad = 0; foreach (rdq[i]) if (rdq[i] !== 24'hFFFFFE + 24'(i)) nbad++;
    total++; if (rdq.size() != 8 || nbad != 0 || rdq[2] !== 24'h000000) $display("FAIL wrap_reads: got %0d reads %0d wrong want 8 reads 0 wrong", rdq.size(), nbad); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    bit ok; int nbad, n;
    clear_mon();
    @(posedge dclk); #1;
    start_addr = 24'h0; start = 1; tx_ready = 1;
    @(posedge dclk); #1;
    start = 0;
    n = 0;
    while (cap.size() < 17 && n < 100) begin @(posedge dclk); #1; n++; end
    total++; if (cap.size() < 17) $display("FAIL rstmid_timeout: got %0d bytes want 17", cap.size()); else pass_cnt++;
    #2 rst = 1;
    #1;
    total++; if (tx_en !== 0 || busy !== 0) $display("FAIL rstmid_async: got tx_en=%b busy=%b want 0 0", tx_en, busy); else pass_cnt++;
    total++; if (vram_rd !== 0 || tx_data !== 8'h00) $display("FAIL rstmid_rd: got vram_rd=%b tx_data=%h want 0 00", vram_rd, tx_data); else pass_cnt++;
    @(posedge dclk); #1;
    rst = 0;
    clear_mon();
    repeat (10) @(posedge dclk);
    #1;
    total++; if (en_cnt != 0 || done_cnt != 0) $display("FAIL rstmid_quiet: got en=%0d done=%0d want 0 0", en_cnt, done_cnt); else pass_cnt++;
    send(24'h123456, 0, 0, ok);
    nbad = 0; foreach (cap[i]) if (cap[i] !== exp_byte(24'h123456, i)) nbad++;
    total++; if (!ok || cap.size() != 31 || nbad != 0) $display("FAIL rstmid_next: got ok=%b %0d bytes %0d wrong want 1 31 0", ok, cap.size(), nbad); else pass_cnt++;
    nbad = 0; foreach (rdq[i]) if (rdq[i] !== 24'h123456 + 24'(i)) nbad++;
    total++; if (rdq.size() != 8 || nbad != 0) $display("FAIL rstmid_reads: got %0d reads %0d wrong want 8 reads 0 wrong", rdq.size(), nbad); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_two_addrs();
    test_stall();
    test_ignore_start();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/vram_packet_tx.md
Name: vram_packet_tx

Overview:
- Transmit-side counterpart of the 8-to-24 receive converter.
- On a start request, reads a run of 24-bit RGB pixels from VRAM and serialises them into the byte stream the receiver consumes.
- Stream format: header 0x05, 0xA8, 0x00, 0x00; 24-bit start address, MSB first; then R,G,B bytes per pixel.
- Sits between the VRAM read port and the Ethernet TX MAC byte interface.

Parameters:
PIXELS, 8, pixels per packet; payload = 3*PIXELS bytes, packet = 7+3*PIXELS bytes (31 default)
HDR0, 8'h05, first header byte
HDR1, 8'hA8, second header byte

Ports:
dclk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to send a packet; sampled only in IDLE
start_addr  in  24  first VRAM pixel address; latched when start is accepted
busy  out  1  high from start acceptance until the last byte is accepted
done  out  1  one-cycle pulse after the last byte is accepted
vram_rd  out  1  VRAM read strobe, one cycle per pixel
vram_addr  out  24  VRAM read address
vram_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}; valid exactly 1 cycle after vram_rd
tx_en  out  1  byte valid; stays high for the whole packet
tx_data  out  8  current byte; 8'h00 whenever tx_en=0
tx_ready  in  1  MAC accepts the byte when tx_en & tx_ready at a rising edge

Behaviour:
- Reset (async, any time, including mid-packet): state=IDLE; busy=0, done=0, vram_rd=0, vram_addr=0, tx_en=0, tx_data=0. Internal byte/pixel counters clear. No partial-packet completion after reset release.
- FSM states: IDLE, HDR, PIX, FIN.
  - IDLE: start=1 latches start_addr into addr_reg and moves to HDR; busy=1 and tx_en=1 from the next cycle, with tx_data=HDR0.
  - HDR: byte index 0..6 emits HDR0, HDR1, 00, 00, addr_reg[23:16], addr_reg[15:8], addr_reg[7:0]. The index advances only on an accepted byte. Acceptance of index 6 moves to PIX.
  - PIX: emits R,G,B for pixel k=0..PIXELS-1 in order. Acceptance of B of the last pixel moves to FIN.
  - FIN: one cycle; tx_en=0, busy=0, done=1; then IDLE.
- Stall: while tx_en=1 and tx_ready=0, tx_data and all counters hold; no vram_rd is issued.
- VRAM read schedule:
  - Pixel k is read exactly once, with vram_addr = addr_reg + k (24-bit, wraps 0xFFFFFF -> 0x000000).
  - The read for pixel 0 is issued in the cycle header byte 5 is accepted.
  - The read for pixel k>0 is issued in the cycle the G byte of pixel k-1 is accepted.
  - vram_data is captured unconditionally on the cycle after vram_rd, whether or not that cycle stalls.
  - B of the current pixel is preserved independently, so a stall on B never corrupts output.
  - vram_rd=0 at all other times; vram_addr holds its last value.
- Throughput: with tx_ready held high, the packet occupies exactly 7+3*PIXELS consecutive tx_en cycles; no bubbles.
- start while busy or in FIN: ignored, not queued.
- Back-to-back: a start in the cycle after FIN (in IDLE) is accepted normally; the minimum gap between packets is 1 idle cycle.
- tx_ready is ignored when tx_en=0.
- Latency: start accepted at edge N -> first byte presented in cycle N+1.

Test Plan:
- start_addr=0, PIXELS=8, tx_ready=1, VRAM model returns {addr,addr+1,addr+2} (lower 8 bits of each) -> 31 bytes: 05 A8 00 00 00 00 00 00 01 02 01 02 03 ...; done 1 cycle after byte 30; 8 vram_rd pulses at addresses 0..7.
- start_addr=50 then, after done, start_addr=100 -> header address bytes 00 00 32, then 00 00 64; vram_addr runs 50..57 and 100..107.
- tx_ready low for 3 cycles on header byte 4, on a G byte, and on a B byte -> tx_data held stable throughout each stall; byte sequence identical to the no-stall case; no extra vram_rd issued.
- start pulsed during HDR and PIX -> ignored; exactly one packet sent, busy never retriggers.
- start_addr=24'hFFFFFE, PIXELS=8 -> vram_addr FFFFFE, FFFFFF, 000000..000005; header bytes FF FF FE.
- rst asserted during pixel 3 -> tx_en, busy, and vram_rd go 0 immediately (async); after release, no output until a new start; the next packet is complete and correct.
